// File: rtl/mc_pkg.sv
// Multicycle MIPS control: shared constants.
// Opcodes, ALU codes, FSM states, datapath selects.
package mc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FUNC_ADD  = 6'b100000;
  localparam logic [5:0] FUNC_SUB  = 6'b100010;
  localparam logic [5:0] FUNC_AND  = 6'b100100;
  localparam logic [5:0] FUNC_OR   = 6'b100101;
  localparam logic [5:0] FUNC_XOR  = 6'b100110;
  localparam logic [5:0] FUNC_SLL  = 6'b000000;
  localparam logic [5:0] FUNC_SRL  = 6'b000010;
  localparam logic [5:0] FUNC_SRA  = 6'b000011;
  localparam logic [5:0] FUNC_JR   = 6'b001000;
  localparam logic [5:0] FUNC_HAMW = 6'b111000;

  localparam logic [3:0] ALUC_ADD  = 4'b0000;
  localparam logic [3:0] ALUC_SUB  = 4'b0100;
  localparam logic [3:0] ALUC_AND  = 4'b0001;
  localparam logic [3:0] ALUC_OR   = 4'b0101;
  localparam logic [3:0] ALUC_XOR  = 4'b0010;
  localparam logic [3:0] ALUC_LUI  = 4'b0110;
  localparam logic [3:0] ALUC_SLL  = 4'b0011;
  localparam logic [3:0] ALUC_SRL  = 4'b0111;
  localparam logic [3:0] ALUC_SRA  = 4'b1111;
  localparam logic [3:0] ALUC_HAMW = 4'b1011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EXE  = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_RS  = 2'b10;
  localparam logic [1:0] PCS_JMP = 2'b11;

  localparam logic [1:0] ASA_PC = 2'b00;
  localparam logic [1:0] ASA_RS = 2'b01;
  localparam logic [1:0] ASA_SA = 2'b10;

  localparam logic [1:0] ASB_RT  = 2'b00;
  localparam logic [1:0] ASB_4   = 2'b01;
  localparam logic [1:0] ASB_IMM = 2'b10;
  localparam logic [1:0] ASB_BR  = 2'b11;

  // R-type func[2:0] and I-type op[2:0] share one
  // encoding for add/sub/and/or/xor.
  function automatic logic [3:0] aluc_arith(
    input logic [2:0] f
  );
    case (f)
      3'b010:  return ALUC_SUB;
      3'b100:  return ALUC_AND;
      3'b101:  return ALUC_OR;
      3'b110:  return ALUC_XOR;
      default: return ALUC_ADD;
    endcase
  endfunction

  function automatic logic [3:0] aluc_shift(
    input logic [1:0] f
  );
    case (f)
      2'b10:   return ALUC_SRL;
      2'b11:   return ALUC_SRA;
      default: return ALUC_SLL;
    endcase
  endfunction

endpackage

// File: rtl/mc_control_decode.sv
// Multicycle MIPS control: op/func classifier.
// Pure combinational instruction-class flags.
module mc_decode
  import mc_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output logic       rtype,
  output logic       shift,
  output logic       itype_log,
  output logic       lw,
  output logic       sw,
  output logic       beq,
  output logic       bne,
  output logic       j,
  output logic       jal,
  output logic       jr,
  output logic       lui,
  output logic       hamw,
  output logic       legal
);

  logic r;
  logic addi;

  assign r = (op == OP_RTYPE);

  assign shift = r && (func inside {
    FUNC_SLL, FUNC_SRL, FUNC_SRA});

  assign hamw = r && (func == FUNC_HAMW);
  assign jr   = r && (func == FUNC_JR);

  // R-format ops that write rd (shifts and hamw included)
  assign rtype = shift || hamw || (r && (func inside {
    FUNC_ADD, FUNC_SUB, FUNC_AND, FUNC_OR, FUNC_XOR}));

  assign itype_log = (op inside {
    OP_ANDI, OP_ORI, OP_XORI});

  assign addi = (op == OP_ADDI);
  assign lui  = (op == OP_LUI);
  assign lw   = (op == OP_LW);
  assign sw   = (op == OP_SW);
  assign beq  = (op == OP_BEQ);
  assign bne  = (op == OP_BNE);
  assign j    = (op == OP_J);
  assign jal  = (op == OP_JAL);

  assign legal = rtype || jr || itype_log || addi
              || lui || lw || sw || beq || bne
              || j || jal;

endmodule

// File: rtl/mc_control.sv
// Multicycle MIPS control unit top.
// Five-step FSM driving datapath selects and strobes.
module mc_control
  import mc_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_wr,
  output logic       iord,
  output logic       ir_wr,
  output logic       pc_wr,
  output logic [1:0] pcsource,
  output logic       reg_wr,
  output logic       regdst,
  output logic       m2reg,
  output logic       jal,
  output logic [3:0] aluc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic       sext,
  output logic       illegal,
  output logic [2:0] state
);

  state_t cur;
  state_t nxt;

  logic d_rtype;
  logic d_shift;
  logic d_itype_log;
  logic d_lw;
  logic d_sw;
  logic d_beq;
  logic d_bne;
  logic d_j;
  logic d_jal;
  logic d_jr;
  logic d_lui;
  logic d_hamw;
  logic d_legal;
  logic [3:0] aluc_op;

  mc_decode u_decode (
    .op        (op),
    .func      (func),
    .rtype     (d_rtype),
    .shift     (d_shift),
    .itype_log (d_itype_log),
    .lw        (d_lw),
    .sw        (d_sw),
    .beq       (d_beq),
    .bne       (d_bne),
    .j         (d_j),
    .jal       (d_jal),
    .jr        (d_jr),
    .lui       (d_lui),
    .hamw      (d_hamw),
    .legal     (d_legal)
  );

  assign state = cur;

  // ALU operation for the latched instruction
  always_comb begin
    aluc_op = ALUC_ADD;
    priority case (1'b1)
      d_hamw:        aluc_op = ALUC_HAMW;
      d_lui:         aluc_op = ALUC_LUI;
      d_shift:       aluc_op = aluc_shift(func[1:0]);
      d_beq, d_bne:  aluc_op = ALUC_SUB;
      d_rtype:       aluc_op = aluc_arith(func[2:0]);
      d_itype_log:   aluc_op = aluc_arith(op[2:0]);
      default:       aluc_op = ALUC_ADD;
    endcase
  end

  // State register, restarts at instruction fetch
  always_ff @(posedge clock) begin
    if (reset) cur <= S_IF;
    else       cur <= nxt;
  end

  // Next state and all datapath controls
  always_comb begin
    nxt      = cur;
    mem_req  = 1'b0;
    mem_wr   = 1'b0;
    iord     = 1'b0;
    ir_wr    = 1'b0;
    pc_wr    = 1'b0;
    pcsource = PCS_ALU;
    reg_wr   = 1'b0;
    regdst   = 1'b0;
    m2reg    = 1'b0;
    jal      = 1'b0;
    aluc     = ALUC_ADD;
    alusrca  = ASA_PC;
    alusrcb  = ASB_RT;
    sext     = 1'b0;
    illegal  = 1'b0;
    if (reset) begin
      nxt = S_IF;
    end else begin
      unique case (cur)
        S_IF: begin
          mem_req = 1'b1;
          alusrcb = ASB_4;
          if (mem_ready) begin
            ir_wr = 1'b1;
            pc_wr = 1'b1;
            nxt   = S_ID;
          end
        end
        S_ID: begin
          // adder forms the branch target meanwhile
          alusrcb = ASB_BR;
          sext    = 1'b1;
          unique case (1'b1)
            d_j: begin
              pc_wr    = 1'b1;
              pcsource = PCS_JMP;
              nxt      = S_IF;
            end
            d_jal: begin
              pc_wr    = 1'b1;
              pcsource = PCS_JMP;
              reg_wr   = 1'b1;
              jal      = 1'b1;
              nxt      = S_IF;
            end
            d_jr: begin
              pc_wr    = 1'b1;
              pcsource = PCS_RS;
              nxt      = S_IF;
            end
            !d_legal: begin
              illegal = 1'b1;
              nxt = ILLEGAL_TRAP ? S_HALT : S_IF;
            end
            default: nxt = S_EXE;
          endcase
        end
        S_EXE: begin
          aluc = aluc_op;
          if (d_rtype) begin
            alusrca = d_shift ? ASA_SA : ASA_RS;
            alusrcb = ASB_RT;
          end else if (d_beq || d_bne) begin
            alusrca = ASA_RS;
            alusrcb = ASB_RT;
          end else begin
            alusrca = ASA_RS;
            alusrcb = ASB_IMM;
            sext    = !d_itype_log;
          end
          unique case (1'b1)
            d_beq: begin
              pc_wr    = z;
              pcsource = PCS_BR;
              nxt      = S_IF;
            end
            d_bne: begin
              pc_wr    = !z;
              pcsource = PCS_BR;
              nxt      = S_IF;
            end
            d_lw, d_sw: nxt = S_MEM;
            default:    nxt = S_WB;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_wr  = d_sw;
          if (mem_ready) nxt = d_lw ? S_WB : S_IF;
        end
        S_WB: begin
          reg_wr = 1'b1;
          regdst = d_rtype;
          m2reg  = d_lw;
          nxt    = S_IF;
        end
        S_HALT: nxt = S_HALT;
        default: nxt = S_IF;
      endcase
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Testbench for mc_control.
// Scoreboard of per-cycle expected control vectors.
module tb_mc_control;
  import mc_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] op = '0;
  logic [5:0] func = '0;
  logic       z = 1'b0;
  logic       mem_ready = 1'b1;
  logic       mem_req, mem_wr, iord, ir_wr, pc_wr;
  logic [1:0] pcsource;
  logic       reg_wr, regdst, m2reg, jal;
  logic [3:0] aluc;
  logic [1:0] alusrca, alusrcb;
  logic       sext, illegal;
  logic [2:0] state;

  mc_control #(.ILLEGAL_TRAP(1'b1)) dut (
    .clock     (clock),
    .reset     (reset),
    .op        (op),
    .func      (func),
    .z         (z),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_wr    (mem_wr),
    .iord      (iord),
    .ir_wr     (ir_wr),
    .pc_wr     (pc_wr),
    .pcsource  (pcsource),
    .reg_wr    (reg_wr),
    .regdst    (regdst),
    .m2reg     (m2reg),
    .jal       (jal),
    .aluc      (aluc),
    .alusrca   (alusrca),
    .alusrcb   (alusrcb),
    .sext      (sext),
    .illegal   (illegal),
    .state     (state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [2:0] st;
    logic       mreq, mwr, iord, irw, pcw;
    logic [1:0] pcs;
    logic       rw, rdst, m2r, jl;
    logic [3:0] alu;
    logic [1:0] sa, sb;
    logic       sx, ill;
  } vec_t;

  typedef struct packed {
    logic       rst, rdy, zz;
    logic [5:0] o, f;
  } stim_t;

  vec_t  exq[$];
  stim_t stq[$];
  int tests_run = 0;
  int tests_failed = 0;

  function automatic vec_t obs();
    vec_t v;
    v = {state, mem_req, mem_wr, iord, ir_wr, pc_wr,
         pcsource, reg_wr, regdst, m2reg, jal, aluc,
         alusrca, alusrcb, sext, illegal};
    return v;
  endfunction

  function automatic vec_t v_if(logic r);
    vec_t v = '0;
    v.mreq = 1'b1;
    v.sb = 2'b01;
    v.irw = r;
    v.pcw = r;
    return v;
  endfunction

  function automatic vec_t v_id();
    vec_t v = '0;
    v.st = 3'd1;
    v.sb = 2'b11;
    v.sx = 1'b1;
    return v;
  endfunction

  function automatic vec_t v_exe(
    logic [1:0] sa, logic [1:0] sb,
    logic sx, logic [3:0] alu
  );
    vec_t v = '0;
    v.st = 3'd2;
    v.sa = sa;
    v.sb = sb;
    v.sx = sx;
    v.alu = alu;
    return v;
  endfunction

  function automatic vec_t v_mem(logic w);
    vec_t v = '0;
    v.st = 3'd3;
    v.mreq = 1'b1;
    v.iord = 1'b1;
    v.mwr = w;
    return v;
  endfunction

  function automatic vec_t v_wb(logic rd, logic m2);
    vec_t v = '0;
    v.st = 3'd4;
    v.rw = 1'b1;
    v.rdst = rd;
    v.m2r = m2;
    return v;
  endfunction

  function automatic vec_t v_halt();
    vec_t v = '0;
    v.st = 3'd5;
    return v;
  endfunction

  task automatic push(stim_t s, vec_t e);
    stq.push_back(s);
    exq.push_back(e);
  endtask

  function automatic stim_t sm(
    logic rst, logic rdy, logic zz,
    logic [5:0] o, logic [5:0] f
  );
    stim_t s;
    s.rst = rst; s.rdy = rdy; s.zz = zz;
    s.o = o; s.f = f;
    return s;
  endfunction

  // push an ALU-style instruction: IF, ID, EXE, WB
  task automatic push_alu(
    logic [5:0] o, logic [5:0] f, vec_t ex, vec_t wb
  );
    push(sm(0, 1, 0, o, f), v_if(1));
    push(sm(0, 1, 0, o, f), v_id());
    push(sm(0, 1, 0, o, f), ex);
    push(sm(0, 1, 0, o, f), wb);
  endtask

  task automatic test_reset();
    vec_t e, o;
    stim_t s;
    int n = 0;
    push(sm(1, 1, 0, 0, 0), '0);
    push(sm(1, 1, 0, 0, 0), '0);
    push(sm(0, 0, 0, 0, 0), v_if(0));
    push(sm(0, 0, 0, 0, 0), v_if(0));
    while (exq.size() > 0) begin
      @(negedge clock);
      s = stq.pop_front();
      reset = s.rst; mem_ready = s.rdy; z = s.zz;
      op = s.o; func = s.f;
      #1;
      e = exq.pop_front(); o = obs();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reset cyc%0d got %h exp %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_add();
    vec_t e, o;
    stim_t s;
    int n = 0;
    vec_t wb = v_wb(1, 0);
    push_alu(OP_RTYPE, FUNC_ADD,
      v_exe(2'b01, 2'b00, 0, 4'b0000), wb);
    push(sm(0, 0, 0, 0, 0), v_if(0));
    while (exq.size() > 0) begin
      @(negedge clock);
      s = stq.pop_front();
      reset = s.rst; mem_ready = s.rdy; z = s.zz;
      op = s.o; func = s.f;
      #1;
      e = exq.pop_front(); o = obs();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL add cyc%0d got %h exp %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_lw_wait();
    vec_t e, o;
    stim_t s;
    int n = 0;
    push(sm(0, 1, 0, OP_LW, 0), v_if(1));
    push(sm(0, 1, 0, OP_LW, 0), v_id());
    push(sm(0, 1, 0, OP_LW, 0),
      v_exe(2'b01, 2'b10, 1, 4'b0000));
    for (int i = 0; i < 4; i++)
      push(sm(0, i == 3, 0, OP_LW, 0), v_mem(0));
    push(sm(0, 1, 0, OP_LW, 0), v_wb(0, 1));
    push(sm(0, 0, 0, OP_LW, 0), v_if(0));
    while (exq.size() > 0) begin
      @(negedge clock);
      s = stq.pop_front();
      reset = s.rst; mem_ready = s.rdy; z = s.zz;
      op = s.o; func = s.f;
      #1;
      e = exq.pop_front(); o = obs();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL lw_wait cyc%0d got %h exp %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_beq();
    vec_t e, o, ex;
    stim_t s;
    int n = 0;
    for (int zv = 1; zv >= 0; zv--) begin
      ex = v_exe(2'b01, 2'b00, 0, 4'b0100);
      ex.pcs = 2'b01;
      ex.pcw = (zv == 1);
      push(sm(0, 1, zv[0], OP_BEQ, 0), v_if(1));
      push(sm(0, 1, zv[0], OP_BEQ, 0), v_id());
      push(sm(0, 1, zv[0], OP_BEQ, 0), ex);
    end
    push(sm(0, 0, 0, 0, 0), v_if(0));
    while (exq.size() > 0) begin
      @(negedge clock);
      s = stq.pop_front();
      reset = s.rst; mem_ready = s.rdy; z = s.zz;
      op = s.o; func = s.f;
      #1;
      e = exq.pop_front(); o = obs();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL beq cyc%0d got %h exp %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_alu_ops();
    vec_t e, o;
    stim_t s;
    int n = 0;
    push_alu(OP_RTYPE, FUNC_HAMW,
      v_exe(2'b01, 2'b00, 0, 4'b1011), v_wb(1, 0));
    push_alu(OP_RTYPE, FUNC_SRA,
      v_exe(2'b10, 2'b00, 0, 4'b1111), v_wb(1, 0));
    push_alu(OP_ORI, 6'b010101,
      v_exe(2'b01, 2'b10, 0, 4'b0101), v_wb(0, 0));
    push_alu(OP_LUI, 6'b000000,
      v_exe(2'b01, 2'b10, 1, 4'b0110), v_wb(0, 0));
    push(sm(0, 0, 0, 0, 0), v_if(0));
    while (exq.size() > 0) begin
      @(negedge clock);
      s = stq.pop_front();
      reset = s.rst; mem_ready = s.rdy; z = s.zz;
      op = s.o; func = s.f;
      #1;
      e = exq.pop_front(); o = obs();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL alu_ops cyc%0d got %h exp %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_back_to_back();
    vec_t e, o, v;
    stim_t s;
    int n = 0;
    push(sm(0, 1, 0, OP_J, 0), v_if(1));
    v = v_id(); v.pcw = 1; v.pcs = 2'b11;
    push(sm(0, 1, 0, OP_J, 0), v);
    push(sm(0, 1, 0, OP_JAL, 0), v_if(1));
    v.rw = 1; v.jl = 1;
    push(sm(0, 1, 0, OP_JAL, 0), v);
    push(sm(0, 1, 0, OP_RTYPE, FUNC_JR), v_if(1));
    v = v_id(); v.pcw = 1; v.pcs = 2'b10;
    push(sm(0, 1, 0, OP_RTYPE, FUNC_JR), v);
    push(sm(0, 1, 0, OP_SW, 0), v_if(1));
    push(sm(0, 1, 0, OP_SW, 0), v_id());
    push(sm(0, 1, 0, OP_SW, 0),
      v_exe(2'b01, 2'b10, 1, 4'b0000));
    push(sm(0, 1, 0, OP_SW, 0), v_mem(1));
    push(sm(0, 1, 0, OP_BNE, 0), v_if(1));
    push(sm(0, 1, 0, OP_BNE, 0), v_id());
    v = v_exe(2'b01, 2'b00, 0, 4'b0100);
    v.pcw = 1; v.pcs = 2'b01;
    push(sm(0, 1, 0, OP_BNE, 0), v);
    push(sm(0, 0, 0, 0, 0), v_if(0));
    while (exq.size() > 0) begin
      @(negedge clock);
      s = stq.pop_front();
      reset = s.rst; mem_ready = s.rdy; z = s.zz;
      op = s.o; func = s.f;
      #1;
      e = exq.pop_front(); o = obs();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL b2b cyc%0d got %h exp %h", n, o, e);
      end
      n++;
    end
  endtask

  task automatic test_illegal();
    vec_t e, o, v;
    stim_t s;
    int n = 0;
    push(sm(0, 1, 0, 6'b111111, 0), v_if(1));
    v = v_id(); v.ill = 1;
    push(sm(0, 1, 0, 6'b111111, 0), v);
    for (int i = 0; i < 10; i++)
      push(sm(0, 1, 0, 6'b111111, 0), v_halt());
    push(sm(1, 1, 0, 6'b111111, 0), v_halt());
    push(sm(0, 0, 0, 0, 0), v_if(0));
    while (exq.size() > 0) begin
      @(negedge clock);
      s = stq.pop_front();
      reset = s.rst; mem_ready = s.rdy; z = s.zz;
      op = s.o; func = s.f;
      #1;
      e = exq.pop_front(); o = obs();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL illegal cyc%0d got %h exp %h", n, o, e);
      end
      n++;
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_lw_wait();
    test_beq();
    test_alu_ops();
    test_back_to_back();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed",
      tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mc_control.md
Name: mc_control

Overview:
- Multicycle MIPS control unit.
- Decodes the latched instruction and drives the ALU's 4-bit aluc plus every datapath select and write strobe, one FSM step per clock.
- Consumes the ALU zero flag z for branch resolution.
- Memory fetch and data accesses use a ready handshake so the datapath tolerates multi-cycle memory.

Parameters:
- ILLEGAL_TRAP, 0, 1 = unrecognised instruction parks FSM in HALT until reset; 0 = treated as NOP (return to IF).

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op  in  6  IR[31:26], valid from ID onward
- func  in  6  IR[5:0], valid from ID onward
- z  in  1  ALU zero flag (s == 0)
- mem_ready  in  1  memory done this cycle
- mem_req  out  1  memory access request (IF, MEM)
- mem_wr  out  1  memory write (sw in MEM)
- iord  out  1  0 = address from PC, 1 = from ALU out
- ir_wr  out  1  load instruction register
- pc_wr  out  1  load PC
- pcsource  out  2  00 ALU, 01 branch target reg, 10 rs (jr), 11 jump addr
- reg_wr  out  1  register file write
- regdst  out  1  1 = rd, 0 = rt
- m2reg  out  1  writeback from MDR
- jal  out  1  write PC into r31
- aluc  out  4  ALU operation
- alusrca  out  2  00 PC, 01 rs, 10 sa
- alusrcb  out  2  00 rt, 01 const 4, 10 imm ext, 11 imm ext << 2
- sext  out  1  sign-extend immediate
- illegal  out  1  pulses one cycle in ID on undecodable instruction
- state  out  3  current state for debug

Behaviour:
- States (package encoding): IF = 0, ID = 1, EXE = 2, MEM = 3, WB = 4, HALT = 5.
- Outputs are combinational from state, op, func and z.
- Reset, while reset = 1:
  - state <= IF.
  - All strobes (pc_wr, ir_wr, reg_wr, mem_wr, mem_req) forced 0.
  - All selects and aluc = 0.
  - illegal = 0.
- Reset asserted mid-access drops mem_req the same cycle; the FSM restarts at IF.
- IF:
  - mem_req = 1, iord = 0, alusrca = 00, alusrcb = 01, aluc = 0000.
  - Stay while mem_ready = 0; no strobes.
  - On mem_ready = 1: ir_wr = 1, pc_wr = 1, pcsource = 00, next state ID.
- ID:
  - alusrca = 00, alusrcb = 11, sext = 1, aluc = 0000 (branch target latched by datapath).
  - j: pc_wr = 1, pcsource = 11, next IF.
  - jal: pc_wr = 1, pcsource = 11, reg_wr = 1, jal = 1, next IF.
  - jr: pc_wr = 1, pcsource = 10, next IF.
  - Undecodable: illegal = 1, next HALT if ILLEGAL_TRAP = 1, else IF.
  - Otherwise: next EXE.
- aluc codes:
  - add, addi, lw, sw = 0000.
  - sub, beq, bne = 0100.
  - and, andi = 0001.
  - or, ori = 0101.
  - xor, xori = 0010.
  - lui = 0110.
  - sll = 0011, srl = 0111, sra = 1111.
  - hamw (op 000000, func 111000) = 1011.
- EXE, operand selects:
  - R-type: alusrca = 01 (10 for shifts), alusrcb = 00.
  - I-type: alusrcb = 10; sext = 0 for andi/ori/xori, 1 otherwise.
- EXE, next state:
  - beq: pc_wr = z, pcsource = 01, next IF.
  - bne: pc_wr = !z, pcsource = 01, next IF.
  - lw/sw: next MEM.
  - Others: next WB.
- MEM:
  - mem_req = 1, iord = 1; mem_wr = 1 for sw.
  - Hold all outputs stable until mem_ready.
  - On mem_ready: lw next WB, sw next IF.
- WB:
  - reg_wr = 1.
  - regdst = 1 for R-type; m2reg = 1 for lw.
  - Next IF.
- HALT: all strobes 0; exits only by reset.
- Latency in cycles, excluding memory wait states:
  - R/I-type ALU: 4.
  - lw: 5.
  - sw: 4.
  - Branches: 3.
  - j/jal/jr: 2.
- pc_wr and reg_wr never assert in the same cycle, except jal in ID.
- mem_wr is never 1 when mem_req is 0.

Decomposition:
- Package mc_pkg:
  - OP_*/FUNC_* opcode constants.
  - ALUC_* codes matching the ALU encoding.
  - State encoding.
  - pcsource/alusrc select constants.
- Sub-module mc_decode: combinational op/func classifier producing instruction-class flags (rtype, shift, itype_log, lw, sw, beq, bne, j, jal, jr, lui, hamw, legal).

Test Plan:
- Reset held 2 cycles with mem_ready = 1 -> state = 0, all strobes 0; first post-reset cycle mem_req = 1, iord = 0.
- add (op 0, func 100000), mem_ready = 1 every cycle -> states IF, ID, EXE, WB, IF; EXE aluc = 0000, alusrcb = 00; WB reg_wr = 1, regdst = 1.
- lw with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, iord = 1, mem_wr = 0 throughout; WB m2reg = 1; total 5 + 3 cycles.
- beq with z = 1, then with z = 0 -> EXE pc_wr = 1, pcsource = 01 for z = 1; pc_wr = 0 for z = 0; both return to IF after 3 cycles.
- hamw (func 111000) and sra (func 000011) -> EXE aluc = 1011 and 1111; sra alusrca = 10.
- op 111111 with ILLEGAL_TRAP = 1 -> illegal pulses in ID, state = 5, no strobes for 10 cycles; reset returns to IF.
